// File: rtl/hwpe_stream_traffic_gen_if.sv
// rtl/hwpe_stream_traffic_gen_if.sv - valid/ready stream bundle used by the traffic generator
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_traffic_gen.sv
// rtl/hwpe_stream_traffic_gen.sv - arithmetic-sequence stream source with LFSR-driven valid stalls
module hwpe_stream_traffic_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] stride_i,
    input  logic [7:0]            stall_thresh_i,
    input  logic [15:0]           seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  beat_cnt_o,
    hwpe_stream_intf_stream.source data_o
);
    localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0]          LFSR_INIT  = 16'hACE1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [LEN_WIDTH-1:0]  len_q,    len_d;
    logic [LEN_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] stride_q, stride_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [7:0]            thresh_q, thresh_d;
    logic [15:0]           lfsr_q,   lfsr_d;
    logic                  valid_q,  valid_d;

    logic handshake;
    logic last_beat;
    logic lfsr_fb;
    logic present;

    assign handshake = valid_q & data_o.ready;
    assign last_beat = (cnt_q == (len_q - LEN_ONE));
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    // Beat is (re)presented only when the LFSR low byte clears the threshold; 0 never stalls.
    assign present   = (lfsr_q[7:0] >= thresh_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        stride_d = stride_q;
        data_d   = data_q;
        thresh_d = thresh_q;
        lfsr_d   = lfsr_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    stride_d = stride_i;
                    thresh_d = stall_thresh_i;
                    data_d   = base_i;
                    cnt_d    = '0;
                    lfsr_d   = (seed_i == 16'h0000) ? LFSR_INIT : seed_i;
                    state_d  = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                lfsr_d = {lfsr_q[14:0], lfsr_fb};
                if (handshake) begin
                    cnt_d  = cnt_q + LEN_ONE;
                    data_d = data_q + stride_q;
                    if (last_beat) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        valid_d = present;
                    end
                end else if (!valid_q) begin
                    valid_d = present;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q    <= '0;
            cnt_q    <= '0;
            stride_q <= '0;
            data_q   <= '0;
            thresh_q <= '0;
            lfsr_q   <= LFSR_INIT;
            valid_q  <= 1'b0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            stride_q <= stride_d;
            data_q   <= data_d;
            thresh_q <= thresh_d;
            lfsr_q   <= lfsr_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o.valid = valid_q;
    assign data_o.data  = data_q;
    assign data_o.strb  = {STRB_WIDTH{valid_q}};

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign beat_cnt_o = cnt_q;
endmodule
